alu_datapath: RTL and testbench
===============================

// Module: alu_datapath
// PURPOSE
//  Register/arithmetic datapath for the 8-bit ALU, directly downstream of the ALU control unit.
//  - Executes the micro-op vector c[10:0] issued by the control unit every cycle.
//  - Returns the status bits the control unit branches on: q_minus_one, q_zero, a_seven, cnt_7.
//  - Supports add, sub, Booth radix-2 multiply and shift/subtract/restore divide.
//  - Operands arrive serially on inbus; results leave serially on outbus.
// PARAMETERS
//  WIDTH  8  operand/register width (A, Q, M, inbus, outbus)
//  CNT_W  3  iteration counter width; cnt_7 asserts at CNT == WIDTH-1
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  c            in   11     micro-op strobes from control unit (decoded below)
//  inbus        in   WIDTH  operand input, sampled on c0/c1
//  outbus       out  WIDTH  registered result output
//  out_valid    out  1      1-cycle pulse: outbus updated this cycle
//  q_zero       out  1      Q[0], combinational from register
//  q_minus_one  out  1      Qm1 register
//  a_seven      out  1      A[WIDTH-1] (sign of A)
//  cnt_7        out  1      CNT == WIDTH-1
//  ovf          out  1      sticky signed overflow of last c10 add/sub
//  err          out  1      sticky illegal micro-op combination flag
// BEHAVIOUR
//  Registers: A, Q, M (WIDTH), Qm1 (1), CNT (CNT_W), outbus, out_valid, ovf, err.
//  - All are 0 after rst; rst has priority over every c bit.
//  Adder operand: opnd = c3 ? (~M + 1) : M. Two's-complement arithmetic, carry-out discarded.
//  Micro-ops, all applied on the same clk edge:
//   c0  Q <= inbus; A <= 0; Qm1 <= 0.
//   c1  M <= inbus; CNT <= 0.
//   c2  A <= A + opnd.
//   c3  subtract select only; no effect without c2 or c10.
//   c4  Q[0] <= 1 (divide quotient bit).
//   c5  if c9: arithmetic right shift of {A,Q,Qm1}, so A[MSB] is kept and Qm1 <= Q[0].
//       else: left shift of {A,Q} with 0 into Q[0].
//       In both cases CNT <= CNT + 1, wrapping 7 -> 0.
//   c6  outbus <= A; out_valid <= 1.
//   c7  outbus <= Q; out_valid <= 1. c7 wins over c6 if both are set.
//   c8  A <= 0; Qm1 <= 0; CNT <= 0. Legal together with c0/c1.
//   c9  shift-direction qualifier only; no effect without c5.
//   c10 Q <= Q + opnd; ovf <= signed overflow of that add/sub.
//  out_valid timing: goes high the cycle after c6/c7 and stays high exactly 1 cycle.
//  Illegal combinations (any pair): c2&c10, c2&c5, c5&c10, c0&c5, c4&c5.
//  - err <= 1 (sticky until rst).
//  - All A/Q/M/Qm1/CNT/ovf updates that cycle are suppressed.
//  - c6/c7 outputs still occur.
//  Status outputs are purely combinational from registers: no added latency, valid the cycle after the update.
//  Idle: c == 0 holds every register; out_valid = 0.
// STRUCTURE
//  Shared package alu_pkg:
//  - localparam indices C_LDQ=0, C_LDM=1, C_ADDA=2, C_SUB=3, C_SETQ0=4, C_SHIFT=5, C_OUTA=6,
//    C_OUTQ=7, C_CLR=8, C_SHR=9, C_ADDQ=10; NUM_C=11.
//  - op_t enum: OP_DIV=2'b00, OP_MUL=2'b01, OP_SUB=2'b10, OP_ADD=2'b11.
//  - The control unit uses the same package.
//  Sub-module alu_addsub, combinational:
//  - inputs a, b, sub; outputs sum, ovf.
//  - Instanced twice: A path and Q path.
// TESTING
//  1 Reset: rst=1 for 1 cycle with random c -> all outputs 0, err=0, out_valid=0.
//  2 Add: c0 inbus=25; c1 inbus=17; c10; c7
//    -> Q=42, outbus=42, out_valid high exactly 1 cycle, ovf=0.
//  3 Sub overflow: Q=8'h80, M=8'h01, c10|c3 -> Q=8'h7F, ovf=1.
//  4 Booth shift: A=8'hF0, Q=8'h03, Qm1=0, c5|c9
//    -> A=8'hF8, Q=8'h01, Qm1=1, CNT+1, q_zero=1, q_minus_one=1.
//  5 Counter wrap: after c1, 7 c5 pulses -> cnt_7=1; 8th pulse -> CNT=0, cnt_7=0.
//  6 Illegal: c2|c10 -> err=1 next cycle, A/Q unchanged; err held until rst.
//  7 Full Booth multiply 6 x -3, driven by the control-unit micro-op sequence
//    -> {A,Q}=16'hFFEE, read out via c6 then c7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared micro-op encoding for the 8-bit ALU control unit and its datapath.
// Also holds the helper that flags micro-op pairs the datapath refuses to execute.
package alu_pkg;

   localparam int C_LDQ   = 0;
   localparam int C_LDM   = 1;
   localparam int C_ADDA  = 2;
   localparam int C_SUB   = 3;
   localparam int C_SETQ0 = 4;
   localparam int C_SHIFT = 5;
   localparam int C_OUTA  = 6;
   localparam int C_OUTQ  = 7;
   localparam int C_CLR   = 8;
   localparam int C_SHR   = 9;
   localparam int C_ADDQ  = 10;
   localparam int NUM_C   = 11;

   typedef enum logic [1:0] {
      OP_DIV = 2'b00,
      OP_MUL = 2'b01,
      OP_SUB = 2'b10,
      OP_ADD = 2'b11
   } op_t;

   // Pairs that would fight over the same register in one cycle.
   function automatic logic illegalCombo(input logic [NUM_C-1:0] cv);
      return (cv[C_ADDA]  & cv[C_ADDQ])  |
             (cv[C_ADDA]  & cv[C_SHIFT]) |
             (cv[C_SHIFT] & cv[C_ADDQ])  |
             (cv[C_LDQ]   & cv[C_SHIFT]) |
             (cv[C_SETQ0] & cv[C_SHIFT]);
   endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational two's-complement adder/subtractor with signed overflow detect.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);

   logic [WIDTH-1:0] opnd;

   // Overflow is judged against the original b so that a - MIN is caught.
   always_comb begin
      opnd = sub ? (~b + 1'b1) : b;
      sum  = a + opnd;
      if (sub) begin
         ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end else begin
         ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
   end

endmodule

// File: rtl/alu_datapath.sv
// A/Q/M register datapath executing the control unit's micro-op vector each cycle,
// covering add, sub, Booth multiply and restoring divide, plus serial in/out.
module alu_datapath
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_C-1:0] c,
   input  logic [WIDTH-1:0] inbus,
   output logic [WIDTH-1:0] outbus,
   output logic             out_valid,
   output logic             q_zero,
   output logic             q_minus_one,
   output logic             a_seven,
   output logic             cnt_7,
   output logic             ovf,
   output logic             err
);

   logic [WIDTH-1:0] regA_q, regA_d, regQ_q, regQ_d, regM_q, regM_d;
   logic [WIDTH-1:0] outbus_q, outbus_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             qm1_q, qm1_d, outValid_q, outValid_d;
   logic             ovf_q, ovf_d, err_q, err_d;
   logic [WIDTH-1:0] sumA, sumQ;
   logic             ovfQ, unusedOvfA, illegal;

   alu_addsub #(.WIDTH(WIDTH)) uAddA (
      .a(regA_q), .b(regM_q), .sub(c[C_SUB]), .sum(sumA), .ovf(unusedOvfA)
   );

   alu_addsub #(.WIDTH(WIDTH)) uAddQ (
      .a(regQ_q), .b(regM_q), .sub(c[C_SUB]), .sum(sumQ), .ovf(ovfQ)
   );

   assign illegal = illegalCombo(c);

   // Loads and clears are applied last so they override arithmetic in the same cycle.
   always_comb begin
      regA_d     = regA_q;
      regQ_d     = regQ_q;
      regM_d     = regM_q;
      qm1_d      = qm1_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      err_d      = err_q | illegal;
      outbus_d   = outbus_q;
      outValid_d = c[C_OUTA] | c[C_OUTQ];
      if (c[C_OUTQ]) begin
         outbus_d = regQ_q;
      end else if (c[C_OUTA]) begin
         outbus_d = regA_q;
      end
      if (!illegal) begin
         if (c[C_ADDA]) begin
            regA_d = sumA;
         end
         if (c[C_ADDQ]) begin
            regQ_d = sumQ;
            ovf_d  = ovfQ;
         end
         if (c[C_SHIFT]) begin
            if (c[C_SHR]) begin
               {regA_d, regQ_d, qm1_d} = {regA_q[WIDTH-1], regA_q, regQ_q};
            end else begin
               {regA_d, regQ_d} = {regA_q[WIDTH-2:0], regQ_q, 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
         end
         if (c[C_SETQ0]) begin
            regQ_d[0] = 1'b1;
         end
         if (c[C_LDQ]) begin
            regQ_d = inbus;
            regA_d = '0;
            qm1_d  = 1'b0;
         end
         if (c[C_LDM]) begin
            regM_d = inbus;
            cnt_d  = '0;
         end
         if (c[C_CLR]) begin
            regA_d = '0;
            qm1_d  = 1'b0;
            cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regA_q     <= '0;
         regQ_q     <= '0;
         regM_q     <= '0;
         qm1_q      <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         outbus_q   <= '0;
         outValid_q <= 1'b0;
      end else begin
         regA_q     <= regA_d;
         regQ_q     <= regQ_d;
         regM_q     <= regM_d;
         qm1_q      <= qm1_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
         outbus_q   <= outbus_d;
         outValid_q <= outValid_d;
      end
   end

   assign outbus      = outbus_q;
   assign out_valid   = outValid_q;
   assign q_zero      = regQ_q[0];
   assign q_minus_one = qm1_q;
   assign a_seven     = regA_q[WIDTH-1];
   assign cnt_7       = (cnt_q == CNT_W'(WIDTH - 1));
   assign ovf         = ovf_q;
   assign err         = err_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Bench for alu_datapath: drives micro-op sequences as the control unit would and
// scoreboards every serial readout against values the bench computes itself.
module tb_alu_datapath;
   import alu_pkg::*;

   localparam logic [NUM_C-1:0] C0  = 11'b1 << C_LDQ;
   localparam logic [NUM_C-1:0] C1  = 11'b1 << C_LDM;
   localparam logic [NUM_C-1:0] C2  = 11'b1 << C_ADDA;
   localparam logic [NUM_C-1:0] C3  = 11'b1 << C_SUB;
   localparam logic [NUM_C-1:0] C5  = 11'b1 << C_SHIFT;
   localparam logic [NUM_C-1:0] C6  = 11'b1 << C_OUTA;
   localparam logic [NUM_C-1:0] C7  = 11'b1 << C_OUTQ;
   localparam logic [NUM_C-1:0] C9  = 11'b1 << C_SHR;
   localparam logic [NUM_C-1:0] C10 = 11'b1 << C_ADDQ;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NUM_C-1:0] c = '0;
   logic [7:0]       inbus = '0;
   logic [7:0]       outbus;
   logic             out_valid, q_zero, q_minus_one, a_seven, cnt_7, ovf, err;

   int         checkCount = 0;
   int         passCount = 0;
   logic [7:0] sb[$];

   alu_datapath #(.WIDTH(8), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .c(c), .inbus(inbus), .outbus(outbus),
      .out_valid(out_valid), .q_zero(q_zero), .q_minus_one(q_minus_one),
      .a_seven(a_seven), .cnt_7(cnt_7), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   // One micro-op cycle: drive mid-cycle, return just after the edge that consumes it.
   task automatic applyStimulus(input logic [NUM_C-1:0] cv, input logic [7:0] iv);
      @(negedge clk);
      c     = cv;
      inbus = iv;
      @(posedge clk);
      #1;
      c     = '0;
      inbus = '0;
   endtask

   task automatic readOut(input bit fromQ, input logic [7:0] expected, input logic [NUM_C-1:0] extra);
      sb.push_back(expected);
      applyStimulus((fromQ ? C7 : C6) | extra, 8'h00);
      for (int k = 0; k < 4 && sb.size() != 0; k++) begin
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         checkOutput("sbTimeout", 16'(sb.size()), 16'd0);
         sb.delete();
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      c   = NUM_C'($urandom);
      @(posedge clk);
      #1;
      rst = 1'b0;
      c   = '0;
   endtask

   // Every outbus update must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("unexpectedValid", 16'd1, 16'd0);
            end else begin
               checkOutput("outbus", 16'(outbus), 16'(sb.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [15:0] product;
      int          prodInt;

      // Reset with random micro-ops
      doReset();
      checkOutput("rstOutbus", 16'(outbus), 16'h0000);
      checkOutput("rstValid", 16'(out_valid), 16'd0);
      checkOutput("rstStatus", 16'({q_zero, q_minus_one, a_seven, cnt_7}), 16'd0);
      checkOutput("rstOvf", 16'(ovf), 16'd0);
      checkOutput("rstErr", 16'(err), 16'd0);

      // Add and single-cycle out_valid
      applyStimulus(C0, 8'd25);
      applyStimulus(C1, 8'd17);
      applyStimulus(C10, 8'd0);
      checkOutput("addOvf", 16'(ovf), 16'd0);
      sb.push_back(8'(25 + 17));
      applyStimulus(C7, 8'd0);
      checkOutput("validHigh", 16'(out_valid), 16'd1);
      @(posedge clk);
      #1;
      checkOutput("validLow", 16'(out_valid), 16'd0);

      // Subtract with overflow
      applyStimulus(C0, 8'h80);
      applyStimulus(C1, 8'h01);
      applyStimulus(C10 | C3, 8'd0);
      checkOutput("subOvf", 16'(ovf), 16'd1);
      readOut(1'b1, 8'h7F, '0);

      // Arithmetic right shift of {A,Q,Qm1}
      applyStimulus(C0, 8'h03);
      applyStimulus(C1, 8'hF0);
      applyStimulus(C2, 8'd0);
      applyStimulus(C5 | C9, 8'd0);
      checkOutput("shrQZero", 16'(q_zero), 16'd1);
      checkOutput("shrQm1", 16'(q_minus_one), 16'd1);
      checkOutput("shrASign", 16'(a_seven), 16'd1);
      readOut(1'b0, 8'hF8, '0);
      readOut(1'b1, 8'h01, '0);

      // Counter wrap at 7 -> 0
      applyStimulus(C1, 8'h01);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(C5, 8'd0);
         if (i == 5) checkOutput("cnt6", 16'(cnt_7), 16'd0);
         if (i == 6) checkOutput("cnt7", 16'(cnt_7), 16'd1);
         if (i == 7) checkOutput("cntWrap", 16'(cnt_7), 16'd0);
      end

      // Illegal combination: state frozen, outputs still produced, err sticky
      applyStimulus(C0, 8'd5);
      applyStimulus(C1, 8'd3);
      applyStimulus(C2, 8'd0);
      applyStimulus(C2 | C10, 8'd0);
      checkOutput("errSet", 16'(err), 16'd1);
      checkOutput("illegalOvfHeld", 16'(ovf), 16'd1);
      readOut(1'b0, 8'd3, '0);
      readOut(1'b1, 8'd5, C5 | C10);
      readOut(1'b1, 8'd5, '0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("errSticky", 16'(err), 16'd1);
      doReset();
      checkOutput("errCleared", 16'(err), 16'd0);

      // Booth multiply 6 x -3, control decisions taken from the status bits
      applyStimulus(C0, 8'hFD);
      applyStimulus(C1, 8'd6);
      for (int i = 0; i < 8; i++) begin
         if (q_zero && !q_minus_one) begin
            applyStimulus(C2 | C3, 8'd0);
         end else if (!q_zero && q_minus_one) begin
            applyStimulus(C2, 8'd0);
         end
         if (i == 7) checkOutput("boothCnt7", 16'(cnt_7), 16'd1);
         applyStimulus(C5 | C9, 8'd0);
      end
      prodInt = 6 * -3;
      product = 16'(prodInt);
      readOut(1'b0, product[15:8], '0);
      readOut(1'b1, product[7:0], '0);

      repeat (2) @(negedge clk);
      checkOutput("sbEmpty", 16'(sb.size()), 16'd0);
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
